regfile_sb: RTL
===============

Name: regfile_sb

Overview:
Parametrised successor of the CPU integer register file. Width, depth and read-port count are configurable. Adds a per-register pending-write scoreboard (outstanding-write counters) so the pipeline can detect RAW hazards. Sits in decode/writeback of the pipelined core: decode reserves destinations, writeback retires them, and a flush clears all reservations on a redirect.

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of architectural registers (power of 2, ≥2); AW = $clog2(NREG)
NRD, 2, number of combinational read ports (1..4)
PEND_W, 2, width of each pending-write counter; max outstanding writes per register = 2^PEND_W-1

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
ra  in  NRD*AW  read addresses, port k at [k*AW +: AW]
rd  out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN]
rbusy  out  NRD  port k register has pending write(s)
we  in  1  writeback enable
wa  in  AW  writeback address
wd  in  XLEN  writeback data
rsv_en  in  1  reserve (issue) a destination
rsv_addr  in  AW  destination being reserved
flush  in  1  clear all pending counters
rsv_ovf  out  1  registered pulse: reserve dropped, counter saturated
wb_unexp  out  1  registered pulse: writeback to a register with count 0

Behaviour:
- Reset: sync, active-high. Next edge: all Q[1..NREG-1]=0, all counters=0, rsv_ovf=0, wb_unexp=0. rd reads 0 and rbusy=0 after reset. Reset mid-operation discards every in-flight reserve, write and flush that cycle.
- Register 0: hardwired zero. Reads return 0, writes ignored, counter always 0, never busy. A reserve to 0 is a no-op with no ovf. A writeback to 0 gives no wb_unexp.
- Write: we && wa!=0 → Q[wa]<=wd at the edge, visible on rd the following cycle (no bypass build).
- Reads: combinational, rd_k = Q[ra_k]. Any number of ports may read the same address.
- Counter update per register r (r!=0), evaluated in this priority order:
  - flush → cnt=0, then the reserve in the same cycle is applied (rsv_addr==r gives cnt=1). A writeback in a flush cycle still writes data but never decrements and never flags.
  - rsv && wb on same r, no flush → cnt unchanged.
  - rsv only → cnt+1 if cnt<max. At max: cnt held, rsv_ovf=1 next cycle.
  - wb only → cnt-1 if cnt>0. At 0: cnt held at 0, data still written, wb_unexp=1 next cycle.
- rbusy_k = (cnt[ra_k]!=0) from current state (no bypass build).
- rsv_ovf/wb_unexp are single-cycle pulses, cleared the following cycle unless re-triggered.

Optional Feature:
Macro REGFILE_SB_BYPASS_EN.
- Defined: write-to-read forwarding. If we && wa==ra_k && ra_k!=0, then rd_k=wd in the same cycle. rbusy_k reflects the counter's next value (the same-cycle writeback retiring the last pending write clears busy combinationally; a same-cycle reserve to ra_k sets it).
- Undefined: rd/rbusy are purely from registered state, and the write becomes visible one cycle later.

Decomposition:
- Package regfile_pkg: XLEN/NREG/NRD/PEND_W defaults, AW derivation function, PEND_MAX constant.
- Sub-module regfile_scoreboard: counter array plus flush/reserve/writeback priority logic, ovf/unexp pulses and busy lookup.
- Data array and read muxing stay in the top.

Test Plan:
- Reset then read all regs on both ports → every rd=0, rbusy=0. Write x5=0xDEADBEEF → ra0=5 reads 0xDEADBEEF next cycle (bypass build: same cycle).
- Write x0=0x1234, rsv_en to 0 → rd of x0=0, rbusy=0, no pulses.
- PEND_W=2: reserve x7 four times → cnt 1,2,3,3. rsv_ovf pulses once after the 4th. rbusy stays 1 until three writebacks, then 0.
- Writeback x9=0x55 with cnt 0 → Q[9]=0x55, wb_unexp=1 for exactly one cycle, cnt stays 0. Same-cycle rsv+wb on x3 with cnt=2 → cnt stays 2.
- Reserve x4,x6 (cnt=1 each), then flush + rsv_en x6 in the same cycle → cnt[4]=0, cnt[6]=1. Flush + we to x4 → data written, no wb_unexp.
- Assert reset mid-stream (cnt[2]=3, we to x2) → next cycle all Q=0, cnt=0, no pulses, x2 reads 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
// Optional same-cycle write forwarding: REGFILE_SB_BYPASS_EN.
package regfile_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int NREG_DEF   = 32;
  localparam int NRD_DEF    = 2;
  localparam int PEND_W_DEF = 2;
  localparam int PEND_MAX   = (1 << PEND_W_DEF) - 1;

  function automatic int calc_aw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write counters with flush/reserve/writeback priority.
// REGFILE_SB_BYPASS_EN makes busy reflect next-cycle counts.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG   = NREG_DEF,
  parameter int NRD    = NRD_DEF,
  parameter int PEND_W = PEND_W_DEF,
  localparam int AW    = calc_aw(NREG)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD-1:0]    rbusy,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  input  logic              flush,
  output logic              rsv_ovf,
  output logic              wb_unexp
);

  localparam logic [PEND_W-1:0] CMAX = '1;
  localparam logic [PEND_W-1:0] CONE = PEND_W'(1);

  logic [PEND_W-1:0] cnt_q [NREG];
  logic [PEND_W-1:0] cnt_d [NREG];
  logic [NREG-1:0]   rsv_sel;
  logic [NREG-1:0]   wb_sel;
  logic [NREG-1:0]   sat;
  logic [NREG-1:0]   idle;
  logic              rsv_ovf_q, rsv_ovf_d;
  logic              wb_unexp_q, wb_unexp_d;

  // Register 0 is masked out so it can never count or flag.
  always_comb begin
    rsv_sel = '0;
    wb_sel  = '0;
    if (rsv_en) rsv_sel[rsv_addr] = 1'b1;
    if (we)     wb_sel[wa]        = 1'b1;
    rsv_sel[0] = 1'b0;
    wb_sel[0]  = 1'b0;
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      sat[r]   = (cnt_q[r] == CMAX);
      idle[r]  = (cnt_q[r] == '0);
      cnt_d[r] = cnt_q[r];
      unique case (1'b1)
        flush:
          cnt_d[r] = rsv_sel[r] ? CONE : '0;
        !flush && rsv_sel[r] && wb_sel[r]: ;
        !flush && rsv_sel[r] && !wb_sel[r]:
          if (!sat[r]) cnt_d[r] = cnt_q[r] + CONE;
        !flush && !rsv_sel[r] && wb_sel[r]:
          if (!idle[r]) cnt_d[r] = cnt_q[r] - CONE;
        default: ;
      endcase
    end
    rsv_ovf_d  = !flush && |(rsv_sel & ~wb_sel & sat);
    wb_unexp_d = !flush && |(wb_sel & ~rsv_sel & idle);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      rsv_ovf_q  <= 1'b0;
      wb_unexp_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      rsv_ovf_q  <= rsv_ovf_d;
      wb_unexp_q <= wb_unexp_d;
    end
  end

  always_comb begin
    for (int k = 0; k < NRD; k++) begin
`ifdef REGFILE_SB_BYPASS_EN
      rbusy[k] = (cnt_d[ra[k*AW +: AW]] != '0);
`else
      rbusy[k] = (cnt_q[ra[k*AW +: AW]] != '0);
`endif
    end
  end

  assign rsv_ovf  = rsv_ovf_q;
  assign wb_unexp = wb_unexp_q;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised integer register file with RAW scoreboard.
// REGFILE_SB_BYPASS_EN forwards writeback data to reads.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NRD    = NRD_DEF,
  parameter int PEND_W = PEND_W_DEF,
  localparam int AW    = calc_aw(NREG)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rbusy,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  input  logic                flush,
  output logic                rsv_ovf,
  output logic                wb_unexp
);

  logic [XLEN-1:0] mem_q [NREG];
  logic [XLEN-1:0] mem_d [NREG];

  always_comb begin
    mem_d = mem_q;
    if (we && wa != '0) mem_d[wa] = wd;
    mem_d[0] = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) mem_q[r] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      rd[k*XLEN +: XLEN] = mem_q[ra[k*AW +: AW]];
`ifdef REGFILE_SB_BYPASS_EN
      if (we && wa == ra[k*AW +: AW] && wa != '0)
        rd[k*XLEN +: XLEN] = wd;
`endif
    end
  end

  regfile_scoreboard #(
    .NREG   (NREG),
    .NRD    (NRD),
    .PEND_W (PEND_W)
  ) u_sb (
    .clock    (clock),
    .reset    (reset),
    .ra       (ra),
    .rbusy    (rbusy),
    .we       (we),
    .wa       (wa),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .flush    (flush),
    .rsv_ovf  (rsv_ovf),
    .wb_unexp (wb_unexp)
  );

endmodule
